// File: rtl/fifo_display_reader.sv
// -----------------------------------------------------------------------------
// fifo_display_reader
//
// Read-side controller for the clock-crossing word buffer. Pops one 16-bit
// word at a time, presents it on a registered output for a programmable
// dwell, and keeps a running (mod 256) count of words popped.
//
// State table:
//   state | meaning
//   IDLE  | buffer empty, nothing in flight
//   READ  | pop strobe high for exactly one cycle
//   WAIT  | popped word valid on fifo_dout; captured on exit
//   HOLD  | word presented; dwell counter runs down (frozen by pause)
//
// Ports:
//   clk         read-domain clock
//   rst         asynchronous active-low reset
//   fifo_empty  buffer empty flag (synchronous to clk)
//   fifo_dout   buffer read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  one-cycle pop strobe
//   prog        dwell select, dwell = DWELL_BASE << prog
//   pause       freezes the dwell counter during HOLD
//   data_out    currently presented word
//   data_valid  high while a word is in its dwell (and across back-to-back pops)
//   parity      even-parity bit of data_out (0 unless READER_PARITY_EN)
//   word_count  words popped, wraps modulo 256
//   busy        high in every state except IDLE
//
// Build option: define READER_PARITY_EN to generate the parity XOR tree.
// -----------------------------------------------------------------------------
module fifo_display_reader #(
  parameter int DATA_W     = 16,
  parameter int CNT_W      = 16,
  parameter int DWELL_BASE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  input  logic [2:0]        prog,
  input  logic              pause,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity,
  output logic [7:0]        word_count,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam int WIDE_W = CNT_W + 8;
  localparam logic [WIDE_W-1:0] BASE_W    = WIDE_W'(DWELL_BASE);
  localparam logic [WIDE_W-1:0] CNT_MAX_W = {{8{1'b0}}, {CNT_W{1'b1}}};

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDE_W-1:0]  dwell_wide;
  logic [CNT_W-1:0]   dwell;
  logic [CNT_W-1:0]   dwell_m1;
  logic               cnt_done;

  // Dwell length: shift in a wider field so large prog values saturate
  // instead of silently wrapping; a zero dwell is promoted to one cycle.
  always_comb begin
    dwell_wide = BASE_W << prog;
    if (dwell_wide > CNT_MAX_W) begin
      dwell = '1;
    end else begin
      dwell = dwell_wide[CNT_W-1:0];
    end
    if (dwell == '0) begin
      dwell = CNT_W'(1);
    end
    dwell_m1 = dwell - CNT_W'(1);
  end

  assign cnt_done = (cnt == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!fifo_empty) state_nxt = READ;
      READ: state_nxt = WAIT;
      WAIT: state_nxt = HOLD;
      HOLD: begin
        if (!pause && cnt_done) begin
          state_nxt = fifo_empty ? IDLE : READ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Output registers; fifo_rd_en and busy are registered from the next state
  // so they line up exactly with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      word_count <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      cnt        <= '0;
    end else begin
      fifo_rd_en <= (state_nxt == READ);
      busy       <= (state_nxt != IDLE);
      if (state == READ) begin
        word_count <= word_count + 8'd1;
      end
      if (state == WAIT) begin
        data_out   <= fifo_dout;
        data_valid <= 1'b1;
        cnt        <= dwell_m1;
      end else if (state == HOLD && !pause) begin
        if (cnt_done) begin
          // Back-to-back pops keep the old word on display until the next capture.
          if (fifo_empty) data_valid <= 1'b0;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
      end
    end
  end

`ifdef READER_PARITY_EN
  assign parity = ^data_out;
`else
  assign parity = 1'b0;
`endif

endmodule
